// File: rtl/key_io_responder_pkg.sv
// Shared constants for memory-mapped device responders: addresses and the
// control/status register bit layout reused by the KEY, SW and timer devices.
package key_io_responder_pkg;

  localparam logic [31:0] KDATA_ADDR = 32'hF000_0010;
  localparam logic [31:0] KCTRL_ADDR = 32'hF000_0110;

  localparam int KCTRL_READY   = 0;
  localparam int KCTRL_OVERRUN = 2;
  localparam int KCTRL_IE      = 8;

  typedef struct packed {
    logic ie;
    logic overrun;
    logic ready;
  } kctrl_t;

  function automatic logic [31:0] kctrl_pack(input kctrl_t c);
    logic [31:0] word;
    word                = '0;
    word[KCTRL_READY]   = c.ready;
    word[KCTRL_OVERRUN] = c.overrun;
    word[KCTRL_IE]      = c.ie;
    return word;
  endfunction

endpackage

// File: rtl/key_io_responder_if.sv
// Data-memory bus seen by a device responder: processor drives address and
// strobes, the responder answers with combinational read data and a hit flag.
interface key_io_responder_if #(
  parameter int DBITS = 32
);
  logic [DBITS-1:0] addr;
  logic             isLoad;
  logic             isStore;
  logic [DBITS-1:0] wrData;
  logic [DBITS-1:0] rdData;
  logic             hit;

  modport master (output addr, isLoad, isStore, wrData, input rdData, hit);
  modport slave  (input addr, isLoad, isStore, wrData, output rdData, hit);
endinterface

// File: rtl/key_io_responder_debouncer.sv
// Two-flop synchroniser plus stability counter for the push-button pins.
// changed_o is high in the cycle whose closing edge loads a new debounced value.
module key_debouncer #(
  parameter int KEY_WIDTH       = 4,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [KEY_WIDTH-1:0] key_i,
  output logic [KEY_WIDTH-1:0] kdata_o,
  output logic                 changed_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [KEY_WIDTH-1:0] sync1_q, sync2_q;
  logic [KEY_WIDTH-1:0] kdata_q, kdata_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // The terminal check precedes the change check so a level that has been
  // stable long enough is committed even if the pin moves again right now.
  always_comb begin
    kdata_d   = kdata_q;
    cnt_d     = cnt_q;
    changed_o = 1'b0;
    if (sync2_q == kdata_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      kdata_d   = sync2_q;
      cnt_d     = '0;
      changed_o = 1'b1;
    end else if (sync1_q != sync2_q) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      kdata_q <= '1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      kdata_q <= kdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign kdata_o = kdata_q;

endmodule

// File: rtl/key_io_responder.sv
// KEY device on the data-memory bus: debounced key value (KDATA) plus
// Ready/Overrun/IE control-status (KCTRL) and a level interrupt request.
module key_io_responder
  import key_io_responder_pkg::*;
#(
  parameter int               DBITS           = 32,
  parameter int               KEY_WIDTH       = 4,
  parameter logic [DBITS-1:0] ADDR_KDATA      = DBITS'(KDATA_ADDR),
  parameter logic [DBITS-1:0] ADDR_KCTRL      = DBITS'(KCTRL_ADDR),
  parameter int               DEBOUNCE_CYCLES = 1000,
  parameter int               CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [KEY_WIDTH-1:0] KEY,
  key_io_responder_if.slave    bus,
  output logic                 intr
);

  logic [KEY_WIDTH-1:0] kdata;
  logic                 key_changed;
  logic                 sel_kdata, sel_kctrl;
  logic                 ld_kdata, st_kctrl;
  kctrl_t               ctrl_q, ctrl_d;
  logic                 unused_wr;

  key_debouncer #(
    .KEY_WIDTH       (KEY_WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_WIDTH       (CNT_WIDTH)
  ) u_debouncer (
    .clk       (clk),
    .reset     (reset),
    .key_i     (KEY),
    .kdata_o   (kdata),
    .changed_o (key_changed)
  );

  assign sel_kdata = (bus.addr == ADDR_KDATA);
  assign sel_kctrl = (bus.addr == ADDR_KCTRL);
  // A cycle with both strobes is a store; it must not consume Ready.
  assign ld_kdata  = bus.isLoad & ~bus.isStore & sel_kdata;
  assign st_kctrl  = bus.isStore & sel_kctrl;

  always_comb begin
    ctrl_d = ctrl_q;
    if (st_kctrl) begin
      ctrl_d.ie = bus.wrData[KCTRL_IE];
      if (!bus.wrData[KCTRL_OVERRUN]) ctrl_d.overrun = 1'b0;
    end
    // A new value overruns only if the previous one is still unread this cycle.
    if (key_changed) begin
      ctrl_d.ready = 1'b1;
      if (ctrl_q.ready && !ld_kdata) ctrl_d.overrun = 1'b1;
    end else if (ld_kdata) begin
      ctrl_d.ready = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  always_comb begin
    bus.rdData = '0;
    if (sel_kdata) begin
      bus.rdData = DBITS'(kdata);
    end else if (sel_kctrl) begin
      bus.rdData = DBITS'(kctrl_pack(ctrl_q));
    end
  end

  assign bus.hit = sel_kdata | sel_kctrl;
  assign intr    = ctrl_q.ready & ctrl_q.ie;

  assign unused_wr = ^{bus.wrData[DBITS-1:KCTRL_IE+1],
                       bus.wrData[KCTRL_IE-1:KCTRL_OVERRUN+1],
                       bus.wrData[KCTRL_OVERRUN-1:0]};

endmodule

// File: tb/tb_key_io_responder.sv
// Directed and randomized bench for key_io_responder against a run-length
// debounce model and a register-level model of KCTRL.
module tb_key_io_responder;

  localparam int          DC      = 4;
  localparam logic [31:0] A_KDATA = 32'hF000_0010;
  localparam logic [31:0] A_KCTRL = 32'hF000_0110;

  logic       clk;
  logic       rst_n;
  logic [3:0] key;
  logic       intr;

  key_io_responder_if #(.DBITS(32)) bif ();

  key_io_responder #(
    .DBITS           (32),
    .KEY_WIDTH       (4),
    .DEBOUNCE_CYCLES (DC),
    .CNT_WIDTH       (16)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .KEY   (key),
    .bus   (bif),
    .intr  (intr)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [3:0] m_pin;    // pin level captured at the previous edge
  logic [3:0] m_sv;     // synchronised level
  int         m_run;    // consecutive edges m_sv has been seen
  logic [3:0] m_kdata;
  logic       m_ready, m_ov, m_ie;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pin   = 4'hF;
    m_sv    = 4'hF;
    m_run   = 0;
    m_kdata = 4'hF;
    m_ready = 1'b0;
    m_ov    = 1'b0;
    m_ie    = 1'b0;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (a == A_KDATA) return {28'h0, m_kdata};
    if (a == A_KCTRL) return (32'(m_ie) << 8) | (32'(m_ov) << 2) | 32'(m_ready);
    return 32'h0;
  endfunction

  // A level is accepted once it has been the synchronised value for DC edges.
  function automatic void model_edge();
    logic upd, ld, st;
    logic [3:0] new_sv;
    if (!rst_n) begin
      model_reset();
      return;
    end
    upd = (m_run >= DC) && (m_sv != m_kdata);
    ld  = bif.isLoad && !bif.isStore && (bif.addr == A_KDATA);
    st  = bif.isStore && (bif.addr == A_KCTRL);
    if (upd && m_ready && !ld) m_ov = 1'b1;
    else if (st && !bif.wrData[2]) m_ov = 1'b0;
    if (st) m_ie = bif.wrData[8];
    if (upd) m_ready = 1'b1;
    else if (ld) m_ready = 1'b0;
    if (upd) m_kdata = m_sv;
    new_sv = m_pin;
    m_run  = (new_sv == m_sv) ? m_run + 1 : 1;
    m_sv   = new_sv;
    m_pin  = key;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
    chk("rd", bif.rdData, exp_rd(bif.addr));
    chk("hit", 32'(bif.hit), 32'((bif.addr == A_KDATA) || (bif.addr == A_KCTRL)));
    chk("intr", 32'(intr), 32'(m_ready & m_ie));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic idle();
    bif.addr    = 32'h0;
    bif.isLoad  = 1'b0;
    bif.isStore = 1'b0;
    bif.wrData  = 32'h0;
  endtask

  task automatic peek(input logic [31:0] a, input string tag, input logic [31:0] exp);
    bif.addr = a;
    #1;
    chk(tag, bif.rdData, exp);
  endtask

  task automatic store_kctrl(input logic [31:0] d);
    bif.addr    = A_KCTRL;
    bif.isStore = 1'b1;
    bif.wrData  = d;
    step();
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    key   = 4'hF;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Reset state
    peek(A_KDATA, "rst_kdata", 32'h0000_000F);
    peek(A_KCTRL, "rst_kctrl", 32'h0);
    chk("rst_intr", 32'(intr), 32'h0);
    idle();

    // KEY[0] pressed: accepted at edge N+5, not before
    key = 4'hE;
    steps(5);
    peek(A_KDATA, "kdata_early", 32'hF);
    idle();
    step();
    peek(A_KDATA, "kdata_n5", 32'hE);
    peek(A_KCTRL, "kctrl_ready", 32'h1);
    bif.addr   = A_KDATA;
    bif.isLoad = 1'b1;
    #1;
    chk("load_kdata", bif.rdData, 32'hE);
    step();
    idle();
    peek(A_KCTRL, "kctrl_consumed", 32'h0);
    idle();

    // Short glitch on KEY[1] never reaches KDATA
    key = 4'hC;
    steps(3);
    key = 4'hE;
    steps(8);
    peek(A_KDATA, "glitch_kdata", 32'hE);
    peek(A_KCTRL, "glitch_kctrl", 32'h0);
    idle();

    // Two unread updates give Overrun; exercise IE and Overrun clear rules
    key = 4'hF;
    steps(6);
    key = 4'hE;
    steps(6);
    peek(A_KCTRL, "overrun", 32'h5);
    idle();
    store_kctrl(32'h104);
    peek(A_KCTRL, "ie_keep_ov", 32'h105);
    chk("intr_on", 32'(intr), 32'h1);
    idle();
    store_kctrl(32'h100);
    peek(A_KCTRL, "ov_clear", 32'h101);
    idle();
    store_kctrl(32'h004);
    peek(A_KCTRL, "ov_w1_ignored", 32'h001);
    chk("intr_off", 32'(intr), 32'h0);
    idle();
    store_kctrl(32'h100);
    idle();

    // Update and KDATA load on the same edge: update wins, no overrun
    key = 4'hF;
    steps(5);
    bif.addr   = A_KDATA;
    bif.isLoad = 1'b1;
    step();
    idle();
    peek(A_KCTRL, "upd_vs_load", 32'h101);
    peek(A_KDATA, "upd_vs_load_kd", 32'hF);
    idle();

    // Asynchronous reset mid-debounce
    key = 4'hE;
    steps(4);
    chk("intr_pre_rst", 32'(intr), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_intr", 32'(intr), 32'h0);
    peek(A_KCTRL, "rst_async_kctrl", 32'h0);
    peek(A_KDATA, "rst_async_kdata", 32'hF);
    model_reset();
    idle();
    step();
    rst_n = 1'b1;
    steps(8);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) key = 4'($urandom);
      case ($urandom_range(3))
        0: bif.addr = A_KDATA;
        1: bif.addr = A_KCTRL;
        2: bif.addr = A_KDATA + 32'h4;
        default: bif.addr = $urandom;
      endcase
      bif.isLoad  = ($urandom_range(2) == 0);
      bif.isStore = ($urandom_range(4) == 0);
      bif.wrData  = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
